// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds frame FSM states, protocol prefix bytes and the scan codes the game reacts to.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int         PS2_DATA_BITS = 8;
    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;

    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_D = 8'h23;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic oddParityOk(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Event bus from the PS/2 receiver to the block-movement controller.
// The receiver drives it through master; consumers observe it through slave.
interface ps2_keyboard_rx_if;

    logic [7:0] ps2_out;
    logic       ps2_key_pressed;
    logic       ps2_extended;
    logic       raw_valid;
    logic [7:0] raw_byte;
    logic       frame_err;

    modport master (
        output ps2_out,
        output ps2_key_pressed,
        output ps2_extended,
        output raw_valid,
        output raw_byte,
        output frame_err
    );

    modport slave (
        input ps2_out,
        input ps2_key_pressed,
        input ps2_extended,
        input raw_valid,
        input raw_byte,
        input frame_err
    );

endinterface

// File: rtl/ps2_keyboard_rx_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, frame FSM and
// inter-edge timeout, producing one pulse per good byte or per broken frame.
import ps2_pkg::*;

module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_ps2Clk,
    input  logic       i_ps2Dat,
    output logic       o_rawValid,
    output logic [7:0] o_rawByte,
    output logic       o_frameErr
);

    localparam int                 CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]         LAST_BIT = 3'(PS2_DATA_BITS - 1);

    logic             r_clkSync1;
    logic             r_clkSync2;
    logic             r_datSync1;
    logic             r_datSync2;
    logic             r_prevClk;
    ps2_state_t       r_state;
    ps2_state_t       w_nextState;
    logic [7:0]       r_shift;
    logic [2:0]       r_bitCnt;
    logic             r_parity;
    logic [CNT_W-1:0] r_toCnt;

    logic w_fall;
    logic w_timeout;
    logic w_frameGood;
    logic w_stopDone;
    logic w_rawValidNext;
    logic w_frameErrNext;

    assign w_fall      = r_prevClk & ~r_clkSync2;
    // A fall in the same cycle wins over an expiring counter.
    assign w_timeout   = (r_state != IDLE) && (r_toCnt == CNT_MAX) && !w_fall;
    assign w_frameGood = r_datSync2 && oddParityOk(r_shift, r_parity);

    // Pins idle high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clkSync1 <= 1'b1;
            r_clkSync2 <= 1'b1;
            r_datSync1 <= 1'b1;
            r_datSync2 <= 1'b1;
            r_prevClk  <= 1'b1;
        end else begin
            r_clkSync1 <= i_ps2Clk;
            r_clkSync2 <= r_clkSync1;
            r_datSync1 <= i_ps2Dat;
            r_datSync2 <= r_datSync1;
            r_prevClk  <= r_clkSync2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_stopDone  = 1'b0;
        if (w_timeout) begin
            w_nextState = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    if (!r_datSync2) w_nextState = DATA;
                DATA:    if (r_bitCnt == LAST_BIT) w_nextState = PARITY;
                PARITY:  w_nextState = STOP;
                STOP: begin
                    w_nextState = IDLE;
                    w_stopDone  = 1'b1;
                end
                default: w_nextState = IDLE;
            endcase
        end
        w_rawValidNext = w_stopDone & w_frameGood;
        w_frameErrNext = w_timeout | (w_stopDone & ~w_frameGood);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift    <= '0;
            r_bitCnt   <= '0;
            r_parity   <= 1'b0;
            r_toCnt    <= '0;
            o_rawValid <= 1'b0;
            o_rawByte  <= '0;
            o_frameErr <= 1'b0;
        end else begin
            o_rawValid <= w_rawValidNext;
            o_frameErr <= w_frameErrNext;
            if (w_rawValidNext) begin
                o_rawByte <= r_shift;
            end

            if (w_fall || r_state == IDLE) begin
                r_toCnt <= '0;
            end else if (r_toCnt != CNT_MAX) begin
                r_toCnt <= r_toCnt + 1'b1;
            end

            if (w_fall) begin
                case (r_state)
                    IDLE:   r_bitCnt <= '0;
                    DATA: begin
                        r_shift  <= {r_datSync2, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                    end
                    PARITY: r_parity <= r_datSync2;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard front end for the game: receives frames and turns make codes
// into single key-press events, dropping break sequences and tagging E0 codes.
import ps2_pkg::*;

module ps2_keyboard_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ps2_clk_in,
    input  logic              ps2_dat_in,
    ps2_keyboard_rx_if.master bus
);

    logic       w_rawValid;
    logic [7:0] w_rawByte;
    logic       w_frameErr;

    logic [7:0] r_out;
    logic       r_keyPressed;
    logic       r_extended;
    logic       r_brkPending;
    logic       r_extPending;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frameRx (
        .clock      (clock),
        .reset      (reset),
        .i_ps2Clk   (ps2_clk_in),
        .i_ps2Dat   (ps2_dat_in),
        .o_rawValid (w_rawValid),
        .o_rawByte  (w_rawByte),
        .o_frameErr (w_frameErr)
    );

    // A broken frame leaves the prefix state unknown, so both flags are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out        <= '0;
            r_keyPressed <= 1'b0;
            r_extended   <= 1'b0;
            r_brkPending <= 1'b0;
            r_extPending <= 1'b0;
        end else begin
            r_keyPressed <= 1'b0;
            if (w_frameErr) begin
                r_brkPending <= 1'b0;
                r_extPending <= 1'b0;
            end else if (w_rawValid) begin
                if (w_rawByte == PS2_BREAK) begin
                    r_brkPending <= 1'b1;
                end else if (w_rawByte == PS2_EXT) begin
                    r_extPending <= 1'b1;
                end else if (r_brkPending) begin
                    r_brkPending <= 1'b0;
                    r_extPending <= 1'b0;
                end else begin
                    r_out        <= w_rawByte;
                    r_extended   <= r_extPending;
                    r_keyPressed <= 1'b1;
                    r_extPending <= 1'b0;
                end
            end
        end
    end

    assign bus.ps2_out         = r_out;
    assign bus.ps2_key_pressed = r_keyPressed;
    assign bus.ps2_extended    = r_extended;
    assign bus.raw_valid       = w_rawValid;
    assign bus.raw_byte        = w_rawByte;
    assign bus.frame_err       = w_frameErr;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: 1 MHz system clock, ~15 kHz PS/2 clock,
// table of frames with expected event counts plus hand sequences for timing, timeout and reset.
`timescale 1ns/1ps

module tb_ps2_keyboard_rx;

    localparam int TO_CYCLES = 100;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ps2Clk = 1'b1;
    logic ps2Dat = 1'b1;

    int cyc = 0;
    int fallCyc = 0;
    int total = 0;
    int bad = 0;

    int rawCnt = 0;
    int keyCnt = 0;
    int errCnt = 0;
    int rawCyc = 0;
    int keyCyc = 0;
    int errCyc = 0;
    logic [7:0] lastRaw = '0;
    logic [7:0] lastOut = '0;
    logic       lastExt = 1'b0;

    typedef struct {
        logic [7:0] code;
        bit         flipPar;
        int         dRaw;
        int         dKey;
        int         dErr;
        logic [7:0] expOut;
        bit         expExt;
    } vec_t;

    vec_t vecs[13];

    ps2_keyboard_rx_if bus ();

    ps2_keyboard_rx #(
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk_in (ps2Clk),
        .ps2_dat_in (ps2Dat),
        .bus        (bus)
    );

    always #500 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Counts every high cycle of each pulse and remembers what came with it.
    always @(negedge clock) begin
        if (bus.raw_valid) begin
            rawCnt  = rawCnt + 1;
            rawCyc  = cyc;
            lastRaw = bus.raw_byte;
        end
        if (bus.ps2_key_pressed) begin
            keyCnt  = keyCnt + 1;
            keyCyc  = cyc;
            lastOut = bus.ps2_out;
            lastExt = bus.ps2_extended;
        end
        if (bus.frame_err) begin
            errCnt = errCnt + 1;
            errCyc = cyc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        @(negedge clock);
        ps2Dat = b;
        repeat (16) @(negedge clock);
        ps2Clk  = 1'b0;
        fallCyc = cyc;
        repeat (33) @(negedge clock);
        ps2Clk = 1'b1;
        repeat (17) @(negedge clock);
    endtask

    // Start bit, nData data bits LSB-first, and for a full frame the odd parity and stop bits.
    task automatic applyStimulus(input logic [7:0] code, input bit flipPar, input int nData);
        logic par;
        sendBit(1'b0);
        for (int i = 0; i < nData; i++) sendBit(code[i]);
        if (nData == 8) begin
            par = ~(^code) ^ flipPar;
            sendBit(par);
            sendBit(1'b1);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ps2_out"},   32'(bus.ps2_out), 32'h0);
        checkOutput({tag, "_key"},       32'(bus.ps2_key_pressed), 32'h0);
        checkOutput({tag, "_ext"},       32'(bus.ps2_extended), 32'h0);
        checkOutput({tag, "_raw_valid"}, 32'(bus.raw_valid), 32'h0);
        checkOutput({tag, "_raw_byte"},  32'(bus.raw_byte), 32'h0);
        checkOutput({tag, "_frame_err"}, 32'(bus.frame_err), 32'h0);
    endtask

    initial begin
        int r0, k0, e0;
        bit seen;

        vecs[0]  = '{8'h23, 1'b0, 1, 1, 0, 8'h23, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 1, 0, 0, 8'h00, 1'b0};
        vecs[2]  = '{8'h23, 1'b0, 1, 0, 0, 8'h00, 1'b0};
        vecs[3]  = '{8'hE0, 1'b0, 1, 0, 0, 8'h00, 1'b0};
        vecs[4]  = '{8'h75, 1'b0, 1, 1, 0, 8'h75, 1'b1};
        vecs[5]  = '{8'h1C, 1'b0, 1, 1, 0, 8'h1C, 1'b0};
        vecs[6]  = '{8'h1C, 1'b1, 0, 0, 1, 8'h00, 1'b0};
        vecs[7]  = '{8'h23, 1'b0, 1, 1, 0, 8'h23, 1'b0};
        vecs[8]  = '{8'hE0, 1'b0, 1, 0, 0, 8'h00, 1'b0};
        vecs[9]  = '{8'hF0, 1'b0, 1, 0, 0, 8'h00, 1'b0};
        vecs[10] = '{8'h75, 1'b0, 1, 0, 0, 8'h00, 1'b0};
        vecs[11] = '{8'h1C, 1'b0, 1, 1, 0, 8'h1C, 1'b0};
        vecs[12] = '{8'hE0, 1'b1, 0, 0, 1, 8'h00, 1'b0};

        $display("[TB] reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkAllZero("reset");

        $display("[TB] first frame timing");
        r0 = rawCnt; k0 = keyCnt;
        applyStimulus(8'h1C, 1'b0, 8);
        repeat (10) @(negedge clock);
        checkOutput("first_raw_cnt", 32'(rawCnt - r0), 32'd1);
        checkOutput("first_raw_byte", 32'(lastRaw), 32'h1C);
        checkOutput("first_raw_latency", 32'(rawCyc - fallCyc), 32'd3);
        checkOutput("first_key_cnt", 32'(keyCnt - k0), 32'd1);
        checkOutput("first_key_after_raw", 32'(keyCyc - rawCyc), 32'd1);
        checkOutput("first_ps2_out", 32'(lastOut), 32'h1C);
        checkOutput("first_ext", 32'(lastExt), 32'h0);

        $display("[TB] frame table");
        for (int i = 0; i < 13; i++) begin
            r0 = rawCnt; k0 = keyCnt; e0 = errCnt;
            applyStimulus(vecs[i].code, vecs[i].flipPar, 8);
            repeat (10) @(negedge clock);
            checkOutput($sformatf("vec%0d_raw_cnt", i), 32'(rawCnt - r0), 32'(vecs[i].dRaw));
            checkOutput($sformatf("vec%0d_key_cnt", i), 32'(keyCnt - k0), 32'(vecs[i].dKey));
            checkOutput($sformatf("vec%0d_err_cnt", i), 32'(errCnt - e0), 32'(vecs[i].dErr));
            if (vecs[i].dRaw > 0)
                checkOutput($sformatf("vec%0d_raw_byte", i), 32'(lastRaw), 32'(vecs[i].code));
            if (vecs[i].dKey > 0) begin
                checkOutput($sformatf("vec%0d_ps2_out", i), 32'(lastOut), 32'(vecs[i].expOut));
                checkOutput($sformatf("vec%0d_ext", i), 32'(lastExt), 32'(vecs[i].expExt));
            end
        end

        $display("[TB] timeout after 4 data bits");
        r0 = rawCnt; k0 = keyCnt; e0 = errCnt;
        applyStimulus(8'h23, 1'b0, 4);
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clock);
            if (errCnt != e0) seen = 1'b1;
        end
        checkOutput("timeout_seen", 32'(seen), 32'd1);
        repeat (5) @(negedge clock);
        checkOutput("timeout_err_cnt", 32'(errCnt - e0), 32'd1);
        checkOutput("timeout_latency", 32'(errCyc - fallCyc), 32'(TO_CYCLES + 3));
        checkOutput("timeout_no_raw", 32'(rawCnt - r0), 32'd0);
        checkOutput("timeout_no_key", 32'(keyCnt - k0), 32'd0);
        k0 = keyCnt;
        applyStimulus(8'h23, 1'b0, 8);
        repeat (10) @(negedge clock);
        checkOutput("after_timeout_key_cnt", 32'(keyCnt - k0), 32'd1);
        checkOutput("after_timeout_ps2_out", 32'(lastOut), 32'h23);

        $display("[TB] reset mid-frame");
        k0 = keyCnt;
        applyStimulus(8'h1C, 1'b0, 5);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkAllZero("midreset");
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        repeat (2 * TO_CYCLES) @(negedge clock);
        checkOutput("midreset_no_key", 32'(keyCnt - k0), 32'd0);
        applyStimulus(8'h1C, 1'b0, 8);
        repeat (10) @(negedge clock);
        checkOutput("midreset_recover_key_cnt", 32'(keyCnt - k0), 32'd1);
        checkOutput("midreset_recover_ps2_out", 32'(lastOut), 32'h1C);
        checkOutput("midreset_recover_ext", 32'(lastExt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives serial frames from a PS/2 keyboard and turns them into one-cycle key-press events for the game logic. It sits between the board's PS/2 pins and the block-movement controller, and drives that controller's `ps2_out` / `ps2_key_pressed` inputs. It filters out break sequences (`F0 xx`), so each physical press produces exactly one event. It also tags `E0`-prefixed codes as extended.

## Interface
- `TIMEOUT_CYCLES`, default 50000: idle clock cycles allowed between PS/2 falling edges inside a frame before the frame is aborted (1 ms at 50 MHz).
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `ps2_clk_in`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_dat_in`  in  1  raw PS/2 data pin, asynchronous.
- `ps2_out`  out  8  last make code delivered; held until the next one.
- `ps2_key_pressed`  out  1  one-cycle pulse; `ps2_out` is valid in that cycle.
- `ps2_extended`  out  1  1 if the delivered code was preceded by `E0`; updated together with `ps2_out`.
- `raw_valid`  out  1  one-cycle pulse per good frame, including `F0` and `E0` frames.
- `raw_byte`  out  8  byte of the last good frame.
- `frame_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Synchronizer:** two flip-flops on each pin, then a `prev_clk` register. Synchronizer flops and `prev_clk` reset to 1.
- **Falling edge:** `fall = prev_clk & ~clk_s2`.
- **Frame FSM states:** IDLE → DATA → PARITY → STOP → IDLE. Transitions happen only on `fall`, except for the timeout.
  - IDLE: on `fall`, if `dat_s2==0` (start bit) go to DATA with `bitcnt=0`. If `dat_s2==1`, stay in IDLE; the bit is silently ignored.
  - DATA: shift `dat_s2` in LSB-first; on `bitcnt==7` go to PARITY.
  - PARITY: latch the parity bit. The frame is good only if the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - STOP: require `dat_s2==1` and good parity. If both hold, pulse `raw_valid` and load `raw_byte`. Otherwise pulse `frame_err`. Return to IDLE either way.
- **Timeout:**
  - The counter clears on every `fall` and in IDLE, and saturates at `TIMEOUT_CYCLES-1`.
  - In any non-IDLE state, reaching `TIMEOUT_CYCLES-1` forces IDLE and pulses `frame_err`. The partial byte is discarded.
- **Decoder** (acts on `raw_valid`):
  - `F0`: set `brk_pending`; no event.
  - `E0`: set `ext_pending`; no event.
  - Any other byte with `brk_pending=1`: clear both flags; no event. This swallows the release.
  - Any other byte with `brk_pending=0`: `ps2_out<=byte`, `ps2_extended<=ext_pending`, pulse `ps2_key_pressed`, clear `ext_pending`.
  - `frame_err` clears both pending flags.
- **Reset values:** all outputs 0, FSM in IDLE, flags 0, counters 0. A reset mid-frame discards the frame; the next `fall` with data 0 starts a fresh frame.
- **Simultaneous events:** `fall` and timeout in the same cycle resolve in favour of `fall` (the counter clears, no error).

## Timing
- Edge 1 is the first rising edge of `clock` that samples `ps2_clk_in` low for the stop bit.
- `raw_valid` / `frame_err` are registered at edge 3 and high for the following cycle.
- `ps2_key_pressed` is registered at edge 4, one cycle after `raw_valid`, and high for exactly one cycle.
- Data is sampled at the detected fall, about 2 cycles after the pin edge. This is well inside the PS/2 data-stable window at any clock ≥1 MHz.
- Maximum event rate is one per frame (about 1 ms); there is no back-pressure and no buffering.

## Structure
- **Package `ps2_pkg`:**
  - FSM state enum `ps2_state_t` (IDLE, DATA, PARITY, STOP).
  - Constants `PS2_BREAK = 8'hF0`, `PS2_EXT = 8'hE0`, `PS2_DATA_BITS = 8`.
  - Scan codes used by the game: `KEY_A = 8'h1C` (move left), `KEY_D = 8'h23` (move right).
- **Sub-module `ps2_frame_rx`:** synchronizer, FSM and timeout, producing `raw_valid` / `raw_byte` / `frame_err`.
- **Top level:** `ps2_keyboard_rx` instantiates `ps2_frame_rx` and holds the make/break/extended decoder.

## Test plan
- Frame `1C` (start 0, data LSB-first, parity 0, stop 1) at a 15 kHz PS/2 clock:
  - `raw_valid` fires with `raw_byte=8'h1C`.
  - One cycle later `ps2_key_pressed` fires with `ps2_out=8'h1C`, `ps2_extended=0`.
- Frames `23`, `F0`, `23`:
  - Exactly one `ps2_key_pressed` pulse (`ps2_out=8'h23`).
  - Three `raw_valid` pulses.
- Frames `E0`, `75`: one event with `ps2_out=8'h75`, `ps2_extended=1`. A following frame `1C` gives `ps2_extended=0`.
- Frame `1C` with the parity bit flipped: `frame_err` pulses once, no `raw_valid`, no event. The next good `23` frame is delivered normally.
- Stop sending after 4 data bits:
  - `frame_err` pulses after `TIMEOUT_CYCLES` cycles (set to 100 in the bench).
  - A following full frame `23` is delivered correctly.
- Assert `reset` for 1 cycle mid-frame (after bit 5):
  - All outputs are 0 the next cycle.
  - The remaining bits produce no event.
  - A subsequent `1C` frame yields an event.
